// File: rtl/button_pkg.sv
// ============================================================================
// Module : button_pkg
// Brief  : Shared per-channel FSM encoding and counter widths for button_scan.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package button_pkg;

    localparam int DB_CNT_W   = 16;
    localparam int HOLD_CNT_W = 24;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    function automatic logic state_is_pressed(input btn_state_e st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module : button_debounce
// Brief  : One button channel: synchronizer, debounce FSM, long-press timer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_press
);

    localparam logic [DB_CNT_W-1:0]   DB_LAST   = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_CNT_W-1:0]   DB_ONE    = DB_CNT_W'(1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_ONE  = HOLD_CNT_W'(1);

    // Synchronizer stores the inverted pin so its reset value means "released".
    logic sync_meta;
    logic sync_pressed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta    <= 1'b0;
            sync_pressed <= 1'b0;
        end else begin
            sync_meta    <= ~btn_n;
            sync_pressed <= sync_meta;
        end
    end

    btn_state_e              state;
    btn_state_e              state_next;
    logic [DB_CNT_W-1:0]     db_cnt;
    logic [DB_CNT_W-1:0]     db_cnt_next;
    logic [HOLD_CNT_W-1:0]   hold_cnt;
    logic [HOLD_CNT_W-1:0]   hold_cnt_next;
    logic                    long_done;
    logic                    long_done_next;
    logic                    level_now;
    logic                    differ;
    logic                    accept;
    logic                    fire_long;

    always_comb begin
        state_next     = state;
        db_cnt_next    = '0;
        hold_cnt_next  = '0;
        long_done_next = 1'b0;
        fire_long      = 1'b0;

        level_now = state_is_pressed(state);
        differ    = (sync_pressed != level_now);
        accept    = differ && (db_cnt == DB_LAST);

        if (differ && !accept) begin
            db_cnt_next = db_cnt + DB_ONE;
        end

        unique case (state)
            ST_RELEASED: begin
                if (sync_pressed) state_next = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (accept)             state_next = ST_PRESSED;
                else if (!sync_pressed) state_next = ST_RELEASED;
            end
            ST_PRESSED: begin
                if (!sync_pressed) state_next = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (accept)            state_next = ST_RELEASED;
                else if (sync_pressed) state_next = ST_PRESSED;
            end
            default: state_next = ST_RELEASED;
        endcase

        // While pressed, accept can only mean a release, which suppresses long.
        if (level_now) begin
            hold_cnt_next  = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HOLD_ONE;
            fire_long      = (hold_cnt == HOLD_LAST) && !long_done && !accept;
            long_done_next = long_done || fire_long;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RELEASED;
            db_cnt     <= '0;
            hold_cnt   <= '0;
            long_done  <= 1'b0;
            level      <= 1'b0;
            press      <= 1'b0;
            rel        <= 1'b0;
            long_press <= 1'b0;
        end else begin
            state      <= state_next;
            db_cnt     <= db_cnt_next;
            hold_cnt   <= hold_cnt_next;
            long_done  <= long_done_next;
            level      <= state_is_pressed(state_next);
            press      <= accept && sync_pressed;
            rel        <= accept && !sync_pressed;
            long_press <= fire_long;
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_scan.sv
// ============================================================================
// Module : button_scan
// Brief  : N_BTN independent debounced push-button channels with events.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_scan
    import button_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic [N_BTN-1:0] BTN_IN,
    output logic [N_BTN-1:0] BTN_STATE,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic [N_BTN-1:0] BTN_LONG
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .clk        (CLK_IN),
            .rst        (RST_IN),
            .btn_n      (BTN_IN[i]),
            .level      (BTN_STATE[i]),
            .press      (BTN_PRESS[i]),
            .rel        (BTN_RELEASE[i]),
            .long_press (BTN_LONG[i])
        );
    end

endmodule

`default_nettype wire
